// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Optional perf counters in instr_fetch_unit are enabled by FETCH_PERF_CNT_EN.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush wins over push and pop.
// Head reads as zero while empty so consumers never see stale storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              wdata,
    output T              rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    // a pop frees the slot, so a full FIFO can still accept a push
    assign w_push = push && (!full || w_pop);
    assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, imem capture into prefetch FIFO, redirect flush.
// Define FETCH_PERF_CNT_EN to add op_fetch_count / op_stall_count outputs.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic [XLEN-1:0]    op_instr_addr_from_proc,
    input  logic [INSTR_W-1:0] ip_instr_from_imem,
    input  logic               ip_instr_valid,
    output logic [INSTR_W-1:0] op_instr,
    output logic [XLEN-1:0]    op_instr_pc,
    output logic               op_instr_valid,
    input  logic               ip_instr_ready,
    input  logic               ip_redirect,
    input  logic [XLEN-1:0]    ip_redirect_pc
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]        op_fetch_count,
    output logic [31:0]        op_stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [AW:0]     w_count;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_rdata;

    // a redirect discards the head, so decode's ready must not consume it
    assign w_pop   = (w_count != '0) && ip_instr_ready && !ip_redirect;
    assign w_push  = ip_instr_valid && !ip_redirect && (!w_full || w_pop);
    assign w_wdata = '{pc: r_pc, instr: ip_instr_from_imem};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (ip_redirect),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (ip_redirect) begin
            r_pc <= {ip_redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    assign op_instr_addr_from_proc = r_pc;
    assign op_instr                = w_rdata.instr;
    assign op_instr_pc             = w_rdata.pc;
    assign op_instr_valid          = !w_empty;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ip_instr_valid && !ip_redirect && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push && r_fetch_cnt != '1)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign op_fetch_count = r_fetch_cnt;
    assign op_stall_count = r_stall_cnt;
`endif

endmodule
